mem_flash_serial_ctrl: RTL and testbench
========================================

Name: mem_flash_serial_ctrl

Overview:
- Host-side master for the serial flash device (Cen/Sclk/Sin/Sout, 8-bit opcode, 24-bit address, MSB first).
- Accepts byte-oriented commands on a valid/ready interface and generates Sclk from the system clock by division.
- Supports single write (0x04), burst write (0x02) and burst read (0x03) with burst length set per command.
- Stalls Sclk on write-data underflow, enforces a post-write busy wait, and enforces a Cen-high gap between transactions.

Parameters:
- ADDR_W, 24: serial address width in bits.
- MAX_BURST, 16: maximum burst length in bytes.
- LEN_W, 5: cmd_len width. Must satisfy 2^LEN_W > MAX_BURST.
- CLK_DIV, 2: Clk cycles per Sclk half-period. Minimum 1.
- WR_WAIT, 40: Clk cycles of busy wait after a write transaction, before done.
- CEN_GAP, 8: minimum Clk cycles Cen stays high between transactions.

Ports:
- Clk  in  1  system clock; all logic on posedge.
- Rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_op  in  8  0x04 single write, 0x02 burst write, 0x03 burst read.
- cmd_addr  in  ADDR_W  start address.
- cmd_len  in  LEN_W  burst length in bytes (1..MAX_BURST); ignored for 0x04.
- wr_valid  in  1  write byte available.
- wr_ready  out  1  one-Clk pulse when wr_data is consumed into the shifter.
- wr_data  in  8  write byte.
- rd_valid  out  1  one-Clk pulse per received byte; no backpressure.
- rd_data  out  8  received byte; held until the next rd_valid.
- busy  out  1  high from command accept until done.
- done  out  1  one-Clk pulse at transaction end.
- err  out  1  one-Clk pulse on an illegal command.
- Cen  out  1  flash chip enable, active low.
- Sclk  out  1  serial clock, idle low.
- Sin  out  1  serial data to flash.
- Sout  in  1  serial data from flash.

Behaviour:
- Reset values:
  - Cen=1, Sclk=0, Sin=0.
  - cmd_ready=1, busy=0, done=0, err=0, wr_ready=0, rd_valid=0, rd_data=0.
  - FSM in IDLE; all counters cleared.
  - Reset mid-transaction aborts immediately with Cen=1 on the next edge; no done pulse.
- Serial timing:
  - Sin changes only while Sclk is low: at Cen fall, then at each Sclk fall.
  - The flash samples Sin on Sclk rise.
  - The controller samples Sout on the Clk edge that raises Sclk.
  - Each Sclk phase lasts CLK_DIV Clk cycles.
- Command accept:
  - Occurs on the Clk edge with cmd_valid & cmd_ready.
  - Latches op, addr and len; len is forced to 1 for 0x04.
  - Illegal op, or len==0 / len>MAX_BURST for 0x02/0x03: err pulses the next cycle, no serial activity, returns to IDLE. busy and done stay low.
- FSM:
  - IDLE: wait for accept.
  - LOAD: for writes, needs wr_valid to load the first byte (wr_ready pulse). Then Cen=0, Sin=opcode MSB.
  - CMD: 8+ADDR_W bits shifted, opcode then address, MSB first.
  - WDATA: 8*len bits, MSB first per byte. At each byte boundary after the first, the next byte is loaded (wr_ready pulse) if wr_valid is high. Otherwise Sclk holds low, Cen holds 0 and Sin holds the last bit until wr_valid rises (stall).
  - RDATA: 8*len bits sampled. A Sout bit is captured on each Sclk rise after the last address bit. rd_valid pulses on the Clk after the 8th bit of each byte.
  - STOP: Cen=1 CLK_DIV cycles after the final Sclk fall.
  - WAIT: held high for CEN_GAP cycles, or max(CEN_GAP, WR_WAIT) cycles after a write. Then done pulses, busy falls and the FSM returns to IDLE.
- Sclk rise counts per transaction:
  - Single write: exactly 8+ADDR_W+8.
  - Burst write/read: 8+ADDR_W+8*len.
- Address wrap-around is the flash's responsibility; the controller sends only the start address.
- cmd_valid during busy is ignored (cmd_ready=0).

Test Plan:
- Single write, CLK_DIV=2: op 0x04, addr 0xFFFFFF, wr_data 0xAA. Required: Sin bitstream 0x04FFFFFFAA (40 Sclk rises), one wr_ready, Cen low ≈160 Clk, then done after WR_WAIT.
- Burst write: op 0x02, addr 0xFFFFA5, len 5, bytes AF,A0,A0,A0,00. Required: 72 Sclk rises, Sin = 0x02FFFFA5 AF A0 A0 A0 00, 5 wr_ready pulses.
- Burst read: op 0x03, addr 0xFFFFA5, len 4, Sout driven with 0x11,0x22,0x33,0xC4. Required: 4 rd_valid pulses with those bytes in order, 64 Sclk rises, done once.
- Underflow stall: burst write len 3, wr_valid dropped for 50 Clk before byte 2. Required: Sclk held low and Cen=0 for the stall, no extra Sclk rises, final bitstream identical to the no-stall run.
- Illegal commands: op 0x03 len 0 → err pulse, Cen never falls. Op 0x05 → err pulse. len 17 with MAX_BURST=16 → err pulse.
- Reset mid-read after 20 Sclk rises → next cycle Cen=1, Sclk=0, cmd_ready=1, no done. A following single write completes normally.

Source files
------------

// File: rtl/mem_flash_serial_ctrl.sv
// Host-side serial flash master: byte-oriented command port, divided Sclk,
// opcode + address + data shifted MSB first, with write stall and busy wait.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | cmd_ready high, waiting for a command handshake
// S_LOAD  | command latched; writes wait here for the first data byte
// S_CMD   | Cen low, shifting opcode then address out on Sin
// S_WDATA | shifting write bytes; may stall with Sclk low between bytes
// S_RDATA | sampling Sout on each Sclk rise, one rd_valid per byte
// S_STOP  | Sclk low after the final fall, Cen still low for one phase
// S_WAIT  | Cen high gap / post-write busy wait, then done
module mem_flash_serial_ctrl #(
   parameter int ADDR_W    = 24,
   parameter int MAX_BURST = 16,
   parameter int LEN_W     = 5,
   parameter int CLK_DIV   = 2,
   parameter int WR_WAIT   = 40,
   parameter int CEN_GAP   = 8
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [7:0]        cmd_op,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [LEN_W-1:0]  cmd_len,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [7:0]        wr_data,
   output logic              rd_valid,
   output logic [7:0]        rd_data,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              Cen,
   output logic              Sclk,
   output logic              Sin,
   input  logic              Sout
);

   localparam int CMD_BITS = 8 + ADDR_W;
   localparam int BIT_W    = $clog2(CMD_BITS + 1);
   localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int WAIT_MAX = (WR_WAIT > CEN_GAP) ? WR_WAIT : CEN_GAP;
   localparam int WAIT_W   = $clog2(WAIT_MAX + 1);

   localparam logic [7:0] OP_SWR = 8'h04;
   localparam logic [7:0] OP_BWR = 8'h02;
   localparam logic [7:0] OP_BRD = 8'h03;

   localparam logic [DIV_W-1:0]  DIV_LOAD  = DIV_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0]  BYTE_BITS = BIT_W'(8);
   localparam logic [WAIT_W-1:0] WAIT_WR   = WAIT_W'(WAIT_MAX - 1);
   localparam logic [WAIT_W-1:0] WAIT_RD   = WAIT_W'(CEN_GAP - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_CMD,
      S_WDATA,
      S_RDATA,
      S_STOP,
      S_WAIT
   } state_t;

   state_t              state_q, state_d;
   logic                is_wr_q, is_wr_d;
   logic [CMD_BITS-1:0] cmd_sr_q, cmd_sr_d;
   logic [7:0]          wbyte_q, wbyte_d;
   logic [6:0]          rbyte_q, rbyte_d;
   logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
   logic [LEN_W-1:0]    byte_cnt_q, byte_cnt_d;
   logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
   logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
   logic                sclk_q, sclk_d;
   logic                stall_q, stall_d;
   logic [7:0]          rd_data_q, rd_data_d;
   logic                rd_valid_q, rd_valid_d;
   logic                done_q, done_d;
   logic                err_q, err_d;

   logic cmd_legal;
   logic cmd_is_wr;
   logic last_bit;
   logic last_byte;

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q    <= S_IDLE;
         is_wr_q    <= 1'b0;
         cmd_sr_q   <= '0;
         wbyte_q    <= '0;
         rbyte_q    <= '0;
         bit_cnt_q  <= '0;
         byte_cnt_q <= '0;
         div_cnt_q  <= '0;
         wait_cnt_q <= '0;
         sclk_q     <= 1'b0;
         stall_q    <= 1'b0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         is_wr_q    <= is_wr_d;
         cmd_sr_q   <= cmd_sr_d;
         wbyte_q    <= wbyte_d;
         rbyte_q    <= rbyte_d;
         bit_cnt_q  <= bit_cnt_d;
         byte_cnt_q <= byte_cnt_d;
         div_cnt_q  <= div_cnt_d;
         wait_cnt_q <= wait_cnt_d;
         sclk_q     <= sclk_d;
         stall_q    <= stall_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   always_comb begin
      cmd_is_wr = (cmd_op == OP_SWR) || (cmd_op == OP_BWR);
      cmd_legal = (cmd_op == OP_SWR) ||
                  (((cmd_op == OP_BWR) || (cmd_op == OP_BRD)) &&
                   (cmd_len != '0) && (cmd_len <= LEN_W'(MAX_BURST)));
      last_bit  = (bit_cnt_q == BIT_W'(1));
      last_byte = (byte_cnt_q == LEN_W'(1));
   end

   always_comb begin
      state_d    = state_q;
      is_wr_d    = is_wr_q;
      cmd_sr_d   = cmd_sr_q;
      wbyte_d    = wbyte_q;
      rbyte_d    = rbyte_q;
      bit_cnt_d  = bit_cnt_q;
      byte_cnt_d = byte_cnt_q;
      div_cnt_d  = div_cnt_q;
      wait_cnt_d = wait_cnt_q;
      sclk_d     = sclk_q;
      stall_d    = stall_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      done_d     = 1'b0;
      err_d      = 1'b0;
      wr_ready   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               if (cmd_legal) begin
                  state_d    = S_LOAD;
                  is_wr_d    = cmd_is_wr;
                  cmd_sr_d   = {cmd_op, cmd_addr};
                  byte_cnt_d = (cmd_op == OP_SWR) ? LEN_W'(1) : cmd_len;
               end else begin
                  err_d = 1'b1;
               end
            end
         end

         S_LOAD: begin
            if (!is_wr_q || wr_valid) begin
               wr_ready  = is_wr_q;
               if (is_wr_q) begin
                  wbyte_d = wr_data;
               end
               state_d   = S_CMD;
               bit_cnt_d = BIT_W'(CMD_BITS);
               div_cnt_d = DIV_LOAD;
               sclk_d    = 1'b0;
               stall_d   = 1'b0;
            end
         end

         S_CMD, S_WDATA, S_RDATA: begin
            if (stall_q) begin
               // Sclk parked low; a fresh low phase starts once the byte lands
               if (wr_valid) begin
                  wr_ready   = 1'b1;
                  wbyte_d    = wr_data;
                  byte_cnt_d = byte_cnt_q - LEN_W'(1);
                  bit_cnt_d  = BYTE_BITS;
                  div_cnt_d  = DIV_LOAD;
                  stall_d    = 1'b0;
               end
            end else if (div_cnt_q != '0) begin
               div_cnt_d = div_cnt_q - DIV_W'(1);
            end else begin
               div_cnt_d = DIV_LOAD;
               if (!sclk_q) begin
                  sclk_d = 1'b1;
                  if (state_q == S_RDATA) begin
                     rbyte_d = {rbyte_q[5:0], Sout};
                     if (last_bit) begin
                        rd_data_d  = {rbyte_q, Sout};
                        rd_valid_d = 1'b1;
                     end
                  end
               end else begin
                  sclk_d = 1'b0;
                  if (!last_bit) begin
                     bit_cnt_d = bit_cnt_q - BIT_W'(1);
                     if (state_q == S_CMD) begin
                        cmd_sr_d = {cmd_sr_q[CMD_BITS-2:0], 1'b0};
                     end
                     if (state_q == S_WDATA) begin
                        wbyte_d = {wbyte_q[6:0], 1'b0};
                     end
                  end else if (state_q == S_CMD) begin
                     state_d   = is_wr_q ? S_WDATA : S_RDATA;
                     bit_cnt_d = BYTE_BITS;
                  end else if (last_byte) begin
                     state_d = S_STOP;
                  end else if (state_q == S_RDATA) begin
                     byte_cnt_d = byte_cnt_q - LEN_W'(1);
                     bit_cnt_d  = BYTE_BITS;
                  end else if (wr_valid) begin
                     wr_ready   = 1'b1;
                     wbyte_d    = wr_data;
                     byte_cnt_d = byte_cnt_q - LEN_W'(1);
                     bit_cnt_d  = BYTE_BITS;
                  end else begin
                     stall_d = 1'b1;
                  end
               end
            end
         end

         S_STOP: begin
            if (div_cnt_q != '0) begin
               div_cnt_d = div_cnt_q - DIV_W'(1);
            end else begin
               state_d    = S_WAIT;
               wait_cnt_d = is_wr_q ? WAIT_WR : WAIT_RD;
            end
         end

         S_WAIT: begin
            if (wait_cnt_q != '0) begin
               wait_cnt_d = wait_cnt_q - WAIT_W'(1);
            end else begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_comb begin
      cmd_ready = (state_q == S_IDLE);
      busy      = (state_q != S_IDLE);
      Cen       = !(state_q inside {S_CMD, S_WDATA, S_RDATA, S_STOP});
      Sclk      = sclk_q;
      if (state_q == S_CMD) begin
         Sin = cmd_sr_q[CMD_BITS-1];
      end else if (state_q == S_WDATA) begin
         Sin = wbyte_q[7];
      end else begin
         Sin = 1'b0;
      end
      rd_valid = rd_valid_q;
      rd_data  = rd_data_q;
      done     = done_q;
      err      = err_q;
   end

endmodule

// File: tb/tb_mem_flash_serial_ctrl.sv
// Bench for mem_flash_serial_ctrl: a flash model on the serial pins, directed
// vectors from a table, a reset-abort sequence and randomized commands.
module tb_mem_flash_serial_ctrl;

   localparam int ADDR_W    = 24;
   localparam int MAX_BURST = 16;
   localparam int LEN_W     = 5;
   localparam int CLK_DIV   = 2;
   localparam int WR_WAIT   = 40;
   localparam int CEN_GAP   = 8;
   localparam int DBITS     = 8 * MAX_BURST;

   logic              Clk = 1'b0;
   logic              Rst;
   logic              cmd_valid;
   logic              cmd_ready;
   logic [7:0]        cmd_op;
   logic [ADDR_W-1:0] cmd_addr;
   logic [LEN_W-1:0]  cmd_len;
   logic              wr_valid;
   logic              wr_ready;
   logic [7:0]        wr_data;
   logic              rd_valid;
   logic [7:0]        rd_data;
   logic              busy;
   logic              done;
   logic              err;
   logic              Cen;
   logic              Sclk;
   logic              Sin;
   logic              Sout = 1'b0;

   mem_flash_serial_ctrl #(
      .ADDR_W(ADDR_W), .MAX_BURST(MAX_BURST), .LEN_W(LEN_W),
      .CLK_DIV(CLK_DIV), .WR_WAIT(WR_WAIT), .CEN_GAP(CEN_GAP)
   ) dut (
      .Clk(Clk), .Rst(Rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
      .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy), .done(done),
      .err(err), .Cen(Cen), .Sclk(Sclk), .Sin(Sin), .Sout(Sout)
   );

   always #5 Clk = ~Clk;

   int tests = 0;
   int fails = 0;

   // observation counters, only ever incremented by the monitors below
   int   rise_cnt = 0, cen_base = 0, cen_falls = 0;
   int   done_cnt = 0, err_cnt = 0, wrr_cnt = 0, viol_cnt = 0;
   int   gap_cyc = 0, cen_low_cyc = 0, done_busy = 0;
   logic seen_low = 1'b0, sclk_prev = 1'b0, sin_prev = 1'b0;
   bit         sin_hist[$];
   logic [7:0] rd_hist[$];
   logic [DBITS-1:0] rd_stream = '0;

   // flash side: capture Sin on Sclk rise, present read data after Sclk fall
   always @(posedge Sclk) begin
      rise_cnt++;
      sin_hist.push_back(Sin);
   end

   always @(negedge Cen) begin
      cen_base = rise_cnt;
      cen_falls++;
   end

   always @(negedge Sclk) begin
      int k;
      k = rise_cnt - cen_base - 32;
      if (!Cen && k >= 0 && k < DBITS) Sout <= rd_stream[DBITS-1-k];
   end

   always @(negedge Clk) begin
      if (done) done_cnt++;
      if (err) err_cnt++;
      if (wr_ready) wrr_cnt++;
      if (rd_valid) rd_hist.push_back(rd_data);
      if (done && busy) done_busy++;
      if (sclk_prev && Sclk && (Sin != sin_prev)) viol_cnt++;
      if (!Cen) begin
         cen_low_cyc++;
         seen_low = 1'b1;
      end else if (busy && seen_low) begin
         gap_cyc++;
      end
      if (!busy) seen_low = 1'b0;
      sclk_prev = Sclk;
      sin_prev  = Sin;
   end

   typedef struct {
      logic [7:0]       op;
      logic [23:0]      addr;
      int               len;
      logic [DBITS-1:0] data;
      int               stall_idx;
      int               stall_len;
      bit               exp_err;
      int               exp_rises;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string name, input longint got, input longint exp);
      tests++;
      if (got != exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic chk_v(input string name, input logic [159:0] got, input logic [159:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   function automatic bit model_legal(input logic [7:0] op, input int len);
      return (op == 8'h04) || ((op == 8'h02 || op == 8'h03) && len >= 1 && len <= MAX_BURST);
   endfunction

   function automatic int model_bytes(input logic [7:0] op, input int len);
      return (op == 8'h04) ? 1 : len;
   endfunction

   task automatic run_txn(input string tag, input vec_t v, input bit exp_err, input int exp_rises);
      int nb, nbits, r0, s0, rd0, d0, e0, w0, c0, vi0, g0, l0, db0;
      bit is_wr, is_rd, lg, timed_out;
      logic [159:0] gv, ev;
      logic [7:0] gb;
      lg    = model_legal(v.op, v.len);
      nb    = model_bytes(v.op, v.len);
      is_wr = (v.op == 8'h04 || v.op == 8'h02);
      is_rd = (v.op == 8'h03);
      r0 = rise_cnt; s0 = sin_hist.size(); rd0 = rd_hist.size(); d0 = done_cnt;
      e0 = err_cnt; w0 = wrr_cnt; c0 = cen_falls; vi0 = viol_cnt; g0 = gap_cyc;
      l0 = cen_low_cyc; db0 = done_busy;
      rd_stream = v.data;
      timed_out = 1'b0;

      @(posedge Clk); #1;
      cmd_valid = 1'b1; cmd_op = v.op; cmd_addr = v.addr; cmd_len = LEN_W'(v.len);
      @(posedge Clk); #1;
      cmd_valid = 1'b0;

      fork
         begin
            int i, hold, cyc;
            i = 0; hold = 0; cyc = 0;
            if (lg && is_wr) begin
               while (i < nb && cyc < 4000) begin
                  if (i == v.stall_idx && i > 0 && hold < v.stall_len) begin
                     wr_valid = 1'b0;
                     if ((rise_cnt - r0) >= 32 + 8 * i) hold++;
                  end else begin
                     wr_valid = 1'b1;
                     wr_data  = v.data[8*(MAX_BURST-1-i) +: 8];
                  end
                  @(negedge Clk);
                  if (wr_valid && wr_ready) i++;
                  @(posedge Clk); #1;
                  cyc++;
               end
            end
            wr_valid = 1'b0;
         end
         begin
            int c;
            c = 0;
            while (done_cnt == d0 && err_cnt == e0 && c < 4000) begin
               @(negedge Clk);
               c++;
            end
            if (done_cnt == d0 && err_cnt == e0) timed_out = 1'b1;
            repeat (12) @(negedge Clk);
         end
      join

      chk({tag, "_timeout"}, timed_out, 0);
      chk({tag, "_err"}, err_cnt - e0, exp_err ? 1 : 0);
      chk({tag, "_done"}, done_cnt - d0, exp_err ? 0 : 1);
      chk({tag, "_rises"}, rise_cnt - r0, exp_rises);
      chk({tag, "_cen_falls"}, cen_falls - c0, exp_err ? 0 : 1);
      if (!exp_err) begin
         chk({tag, "_wr_ready"}, wrr_cnt - w0, is_wr ? nb : 0);
         nbits = is_wr ? 32 + 8 * nb : 32;
         gv = '0; ev = '0;
         for (int b = 0; b < nbits; b++) begin
            gv = {gv[158:0], (s0 + b < sin_hist.size()) ? sin_hist[s0 + b] : 1'b0};
            if (b < 8)       ev = {ev[158:0], v.op[7-b]};
            else if (b < 32) ev = {ev[158:0], v.addr[31-b]};
            else             ev = {ev[158:0], v.data[DBITS-1-(b-32)]};
         end
         chk_v({tag, "_sin_stream"}, gv, ev);
         chk({tag, "_sin_stable"}, viol_cnt - vi0, 0);
         chk({tag, "_wait_gap"}, gap_cyc - g0, is_wr ? ((WR_WAIT > CEN_GAP) ? WR_WAIT : CEN_GAP) : CEN_GAP);
         chk({tag, "_done_busy"}, done_busy - db0, 0);
         if (v.stall_len == 0)
            chk({tag, "_cen_low"}, cen_low_cyc - l0, 2 * CLK_DIV * (32 + 8 * nb) + CLK_DIV);
         if (is_rd) begin
            chk({tag, "_rd_count"}, rd_hist.size() - rd0, nb);
            for (int b = 0; b < nb; b++) begin
               gb = (rd0 + b < rd_hist.size()) ? rd_hist[rd0 + b] : 8'h00;
               chk($sformatf("%s_rd_byte%0d", tag, b), gb, v.data[8*(MAX_BURST-1-b) +: 8]);
            end
         end
      end
   endtask

   initial begin
      vec_t rv;
      int r0, d0, c;
      Rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_len = '0;
      wr_valid = 1'b0; wr_data = '0;

      //           op     addr        len data                                            sidx slen err rises
      vecs[0] = '{8'h04, 24'hFFFFFF, 0,  {8'hAA, 120'h0},                                0, 0,  0, 40};
      vecs[1] = '{8'h02, 24'hFFFFA5, 5,  {40'hAFA0A0A000, 88'h0},                        0, 0,  0, 72};
      vecs[2] = '{8'h03, 24'hFFFFA5, 4,  {32'h112233C4, 96'h0},                          0, 0,  0, 64};
      vecs[3] = '{8'h02, 24'h123456, 3,  {24'h5AC30F, 104'h0},                           1, 50, 0, 56};
      vecs[4] = '{8'h02, 24'h123456, 3,  {24'h5AC30F, 104'h0},                           0, 0,  0, 56};
      vecs[5] = '{8'h03, 24'h000010, 0,  '0,                                             0, 0,  1, 0};
      vecs[6] = '{8'h05, 24'h000010, 2,  '0,                                             0, 0,  1, 0};
      vecs[7] = '{8'h02, 24'h000010, 17, '0,                                             0, 0,  1, 0};
      vecs[8] = '{8'h02, 24'h800001, 16, 128'h0123456789ABCDEFFEDCBA9876543210,          0, 0,  0, 160};

      repeat (3) @(posedge Clk);
      #1 Rst = 1'b0;
      #1;
      chk("rst_cen", Cen, 1);
      chk("rst_sclk", Sclk, 0);
      chk("rst_sin", Sin, 0);
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_wr_ready", wr_ready, 0);
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_rd_data", rd_data, 0);

      for (int i = 0; i < 9; i++)
         run_txn($sformatf("vec%0d", i), vecs[i], vecs[i].exp_err, vecs[i].exp_rises);

      // reset in the middle of a burst read, with a command offered while busy
      r0 = rise_cnt; d0 = done_cnt;
      rd_stream = {32'hDEADBEEF, 96'h0};
      @(posedge Clk); #1;
      cmd_valid = 1'b1; cmd_op = 8'h03; cmd_addr = 24'hABCDEF; cmd_len = LEN_W'(4);
      @(posedge Clk); #1;
      cmd_op = 8'h04;
      repeat (3) @(posedge Clk);
      @(negedge Clk);
      chk("busy_cmd_ready", cmd_ready, 0);
      chk("busy_busy", busy, 1);
      @(posedge Clk); #1;
      cmd_valid = 1'b0;
      c = 0;
      while ((rise_cnt - r0) < 20 && c < 2000) begin
         @(negedge Clk);
         c++;
      end
      chk("midrd_reached_20", ((rise_cnt - r0) >= 20) ? 1 : 0, 1);
      @(posedge Clk); #1;
      Rst = 1'b1;
      @(posedge Clk); #1;
      chk("midrd_cen", Cen, 1);
      chk("midrd_sclk", Sclk, 0);
      chk("midrd_cmd_ready", cmd_ready, 1);
      chk("midrd_busy", busy, 0);
      Rst = 1'b0;
      repeat (60) @(negedge Clk);
      chk("midrd_no_done", done_cnt - d0, 0);
      rv = '{8'h04, 24'h000001, 7, {8'h3C, 120'h0}, 0, 0, 0, 40};
      run_txn("post_reset_wr", rv, 0, 40);

      // randomized commands against the reference model
      for (int t = 0; t < 14; t++) begin
         int sel;
         sel = $urandom_range(0, 4);
         case (sel)
            0: rv.op = 8'h02;
            1: rv.op = 8'h03;
            2: rv.op = 8'h04;
            3: rv.op = 8'h03;
            default: begin
               rv.op = 8'($urandom_range(0, 255));
               if (rv.op inside {8'h02, 8'h03, 8'h04}) rv.op = 8'hFF;
            end
         endcase
         rv.addr = 24'($urandom);
         rv.len  = $urandom_range(0, 18);
         for (int b = 0; b < MAX_BURST; b++) rv.data[8*b +: 8] = 8'($urandom_range(0, 255));
         rv.stall_idx = 0; rv.stall_len = 0;
         if (rv.op == 8'h02 && rv.len > 1 && rv.len <= MAX_BURST && $urandom_range(0, 1) == 1) begin
            rv.stall_idx = $urandom_range(1, rv.len - 1);
            rv.stall_len = $urandom_range(5, 30);
         end
         rv.exp_err   = !model_legal(rv.op, rv.len);
         rv.exp_rises = rv.exp_err ? 0 : 32 + 8 * model_bytes(rv.op, rv.len);
         run_txn($sformatf("rnd%0d_op%0h_len%0d", t, rv.op, rv.len), rv, rv.exp_err, rv.exp_rises);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
